// File: rtl/alu_result_stage.sv
// alu_result_stage
// Registered result stage behind the ALU add/sub unit. It either passes the
// sum through or turns the z/v/n flags into a Beta compare result. Results go
// to writeback through a 2-entry skid buffer, so upstream ready is a flop.
// The stage also keeps a sticky overflow flag for the exception logic.
//
// Handshake: a beat moves on any rising edge where valid and ready are both
// high on that interface. Ready may be high with valid low. Once valid is
// raised, the payload holds stable until the beat is taken. in_ready comes
// straight from a flop. It is low only when both storage entries are full.
//
// Storage is a main register and a skid register. The main register drives
// out_data/out_rc. The FSM state encodes which entries hold live data:
// EMPTY (none), ONE (main only), FULL (main and skid).

module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       fn,
    input  logic [WIDTH-1:0] arithout,
    input  logic             z,
    input  logic             v,
    input  logic             n,
    input  logic [TAGW-1:0]  rc_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAGW-1:0]  out_rc,
    output logic             ovf_sticky,
    input  logic             ovf_clr,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] main_data;
    logic [TAGW-1:0]  main_rc;
    logic [WIDTH-1:0] skid_data;
    logic [TAGW-1:0]  skid_rc;
    logic [WIDTH-1:0] result;

    logic in_ready_q;
    logic ovf_q;
    logic accept;
    logic xfer;

    // Register-load controls decided together with the next state.
    logic load_main_in;
    logic load_skid_in;
    logic load_main_skid;

    // Handshake events: accept uses the registered ready. A transfer can only
    // happen when the main register holds a live entry.
    assign accept = in_valid && in_ready_q;
    assign xfer   = (state != EMPTY) && out_ready;

    // Result function: pass the sum, or build a 0/1 compare result.
    // Bits above bit 0 stay zero for compares.
    always_comb begin
        result = '0;
        case (fn)
            2'b00:   result    = arithout;
            2'b01:   result[0] = z;
            2'b10:   result[0] = n ^ v;
            2'b11:   result[0] = z | (n ^ v);
            default: result    = '0;
        endcase
    end

    // State register. Reset drops any buffered entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and load-control logic for the two-entry buffer.
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next   = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && xfer) begin
                    // The head leaves as the new entry takes its place.
                    state_next   = ONE;
                    load_main_in = 1'b1;
                end else if (accept) begin
                    // Main is still waiting, so park the new entry in skid.
                    state_next   = FULL;
                    load_skid_in = 1'b1;
                end else if (xfer) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so no accept can occur.
                if (xfer) begin
                    state_next     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Output decode from the current state and the storage registers.
    always_comb begin
        out_valid  = (state != EMPTY);
        out_data   = main_data;
        out_rc     = main_rc;
        in_ready   = in_ready_q;
        ovf_sticky = ovf_q;
        state_dbg  = state;
    end

    // Registered ready: high whenever the skid register will be free next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_next != FULL);
        end
    end

    // Main and skid data registers. They clear on reset and otherwise keep
    // their last value while invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_data <= '0;
            main_rc   <= '0;
            skid_data <= '0;
            skid_rc   <= '0;
        end else begin
            if (load_main_in) begin
                main_data <= result;
                main_rc   <= rc_in;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_rc   <= skid_rc;
            end
            if (load_skid_in) begin
                skid_data <= result;
                skid_rc   <= rc_in;
            end
        end
    end

    // Sticky overflow: only an accepted pass-op with v set raises it.
    // A set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (accept && (fn == 2'b00) && v) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage. A queue-based reference model tracks the
// entries held in the stage and the sticky overflow flag.

module tb_alu_result_stage;

    localparam int WIDTH = 32;
    localparam int TAGW  = 5;
    localparam int EW    = TAGW + WIDTH;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       fn;
    logic [WIDTH-1:0] arithout;
    logic             z;
    logic             v;
    logic             n;
    logic [TAGW-1:0]  rc_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAGW-1:0]  out_rc;
    logic             ovf_sticky;
    logic             ovf_clr;
    logic [1:0]       state_dbg;

    int checks;
    int failures;

    // Reference model: the entries the stage should hold, oldest first, as {rc, data}.
    logic [EW-1:0] exp_q[$];
    logic          m_ovf;

    alu_result_stage #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fn         (fn),
        .arithout   (arithout),
        .z          (z),
        .v          (v),
        .n          (n),
        .rc_in      (rc_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rc     (out_rc),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr),
        .state_dbg  (state_dbg)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beta result rules.
    function automatic logic [WIDTH-1:0] ref_result(input logic [1:0] f,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic fz, input logic fn_n,
                                                    input logic fv);
        logic lt;
        lt = (fn_n != fv);
        if (f == 2'd0) return a;
        if (f == 2'd1) return fz ? 1 : 0;
        if (f == 2'd2) return lt ? 1 : 0;
        return (fz || lt) ? 1 : 0;
    endfunction

    // One clock: inputs are already driven. The model advances at the edge,
    // and outputs are ready to sample 1 time unit later.
    task automatic cycle();
        logic acc;
        logic xf;
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            acc = in_valid && (exp_q.size() < 2);
            xf  = (exp_q.size() > 0) && out_ready;
            if (xf) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({rc_in, ref_result(fn, arithout, z, n, v)});
            if (acc && fn == 2'd0 && v) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
        #1;
    endtask

    task automatic drive(input logic vld, input logic [1:0] f, input logic [WIDTH-1:0] a,
                         input logic fz, input logic fv, input logic fnn,
                         input logic [TAGW-1:0] rc);
        in_valid = vld;
        fn       = f;
        arithout = a;
        z        = fz;
        v        = fv;
        n        = fnn;
        rc_in    = rc;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, '0);
        ovf_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        out_ready = 1'b0;
        reset = 1'b1;
        drive(1'b1, 2'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 5'd7);
        cycle();
        cycle();
        reset = 1'b0;
        idle();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_data !== '0 || out_rc !== '0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", out_data, out_rc); end
        checks++;
        if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf_sticky); end
        checks++;
        if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    endtask

    task automatic test_pass();
        out_ready = 1'b1;
        drive(1'b1, 2'd0, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 5'd3);
        cycle();
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd5 || out_rc !== 5'd3) begin
            failures++;
            $display("FAIL pass_first got=v%b d=%h rc=%0d exp=v1 d=5 rc=3", out_valid, out_data, out_rc);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL pass_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_compare();
        // Each entry is {fn, z, n, v, expected bit}.
        logic [5:0] tbl [5];
        logic [WIDTH-1:0] expd;
        tbl[0] = {2'd2, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[1] = {2'd2, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = {2'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = {2'd3, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[4] = {2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, tbl[i][5:4], $urandom | 32'h8000_0000, tbl[i][3], tbl[i][1], tbl[i][2], 5'(i + 10));
            cycle();
            idle();
            expd = {{(WIDTH-1){1'b0}}, tbl[i][0]};
            checks++;
            if (out_valid !== 1'b1 || out_data !== expd || out_rc !== 5'(i + 10)) begin
                failures++;
                $display("FAIL compare_%0d got=v%b d=%h rc=%0d exp=v1 d=%h rc=%0d",
                         i, out_valid, out_data, out_rc, expd, i + 10);
            end
            cycle();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 32'h11, 1'b0, 1'b0, 1'b0, 5'd1);
        cycle();
        drive(1'b1, 2'd0, 32'h22, 1'b0, 1'b0, 1'b0, 5'd2);
        cycle();
        idle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (state_dbg !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'h11 || out_rc !== 5'd1) begin
                failures++;
                $display("FAIL bp_full_%0d got=st%0d rdy%b d=%h exp=st2 rdy0 d=11", k, state_dbg, in_ready, out_data);
            end
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h22 || out_rc !== 5'd2 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_second got=v%b d=%h rdy%b exp=v1 d=22 rdy1", out_valid, out_data, in_ready);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 2'd0, WIDTH'(i), 1'b0, 1'b0, 1'b0, 5'(i));
            cycle();
            checks++;
            if (out_valid !== 1'b1 || out_data !== WIDTH'(i) || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_%0d got=v%b d=%h rdy%b exp=v1 d=%h rdy1", i, out_valid, out_data, in_ready, i);
            end
        end
        idle();
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_sticky();
        out_ready = 1'b1;
        idle();
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        drive(1'b1, 2'd0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 5'd4);
        cycle();
        checks++;
        if (ovf_sticky !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf_sticky); end
        idle();
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        drive(1'b1, 2'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 5'd5);
        cycle();
        checks++;
        if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL ovf_cmp_noset got=%b exp=0", ovf_sticky); end
        drive(1'b1, 2'd0, 32'h1, 1'b0, 1'b1, 1'b0, 5'd6);
        cycle();
        drive(1'b1, 2'd0, 32'h2, 1'b0, 1'b1, 1'b0, 5'd7);
        ovf_clr = 1'b1;
        cycle();
        checks++;
        if (ovf_sticky !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", ovf_sticky); end
        idle();
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        checks++;
        if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ovf_sticky); end
        cycle();
    endtask

    task automatic test_random();
        logic [EW-1:0] head;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
                  1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            ovf_clr   = ($urandom_range(0, 9) == 0);
            reset     = ($urandom_range(0, 79) == 0);
            cycle();
            checks++;
            if (out_valid !== (exp_q.size() > 0) || in_ready !== (exp_q.size() < 2) ||
                ovf_sticky !== m_ovf || state_dbg !== 2'(exp_q.size())) begin
                failures++;
                $display("FAIL rand_ctrl_%0d got=v%b rdy%b ovf%b st%0d exp=occ%0d ovf%b",
                         i, out_valid, in_ready, ovf_sticky, state_dbg, exp_q.size(), m_ovf);
            end
            if (exp_q.size() > 0) begin
                head = exp_q[0];
                checks++;
                if ({out_rc, out_data} !== head) begin
                    failures++;
                    $display("FAIL rand_data_%0d got=%h/%h exp=%h/%h", i, out_rc, out_data,
                             head[EW-1:WIDTH], head[WIDTH-1:0]);
                end
            end
        end
        reset = 1'b0;
        idle();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 32'hAAAA_0001, 1'b0, 1'b1, 1'b0, 5'd8);
        cycle();
        drive(1'b1, 2'd0, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0, 5'd9);
        cycle();
        idle();
        checks++;
        if (state_dbg !== 2'd2 || ovf_sticky !== 1'b1) begin
            failures++;
            $display("FAIL mid_full got=st%0d ovf%b exp=st2 ovf1", state_dbg, ovf_sticky);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_sticky !== 1'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL mid_reset got=v%b rdy%b ovf%b d=%h exp=v0 rdy1 ovf0 d=0",
                     out_valid, in_ready, ovf_sticky, out_data);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_dropped_%0d got=%b exp=0", k, out_valid); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_ovf    = 1'b0;
        reset    = 1'b1;
        out_ready = 1'b0;
        idle();
        test_reset();
        test_pass();
        test_compare();
        test_backpressure();
        test_streaming();
        test_sticky();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered result stage directly downstream of the ALU add/subtract unit in the beta processor datapath.
- Consumes the 32-bit sum/difference and its z/v/n flags. Either passes the sum through or turns it into a Beta compare result (CMPEQ/CMPLT/CMPLE).
- Delivers the result to writeback over a valid/ready handshake, using a 2-entry skid buffer so upstream ready is registered.
- Also maintains a sticky overflow flag for exception logic.

Parameters:
- WIDTH, 32, data width of the arithmetic result and output data.
- TAGW, 5, width of the destination-register tag carried with each result.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream result and flags are valid this cycle.
- in_ready  output  1  stage can accept this cycle; driven from a register.
- fn  input  2  00 pass, 01 CMPEQ, 10 CMPLT, 11 CMPLE.
- arithout  input  WIDTH  sum/difference from the ALU add/sub unit.
- z  input  1  zero flag from the ALU add/sub unit.
- v  input  1  overflow flag from the ALU add/sub unit.
- n  input  1  negative flag from the ALU add/sub unit.
- rc_in  input  TAGW  destination register tag.
- out_valid  output  1  out_data and out_rc are valid.
- out_ready  input  1  writeback accepts this cycle.
- out_data  output  WIDTH  final result.
- out_rc  output  TAGW  tag paired with out_data.
- ovf_sticky  output  1  set by any accepted pass-op (fn=00) with v=1.
- ovf_clr  input  1  clears ovf_sticky.

Behaviour:
- Accept occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Result function, evaluated at accept:
  - fn=00: arithout.
  - fn=01: {0..., z}.
  - fn=10: {0..., n^v}.
  - fn=11: {0..., z|(n^v)}.
  - Bits [WIDTH-1:1] of compare results are zero.
- Storage: main register (drives out_data/out_rc) and skid register, each with its own valid bit.
- States: EMPTY (neither valid), ONE (main valid), FULL (both valid).
- out_valid = main valid.
- in_ready = !skid_valid, registered; it is 1 in EMPTY and ONE and 0 in FULL.
- EMPTY:
  - accept -> ONE; the entry is loaded into main.
- ONE:
  - accept and transfer -> ONE; new entry goes into main.
  - accept, no transfer -> FULL; new entry goes into skid, main holds.
  - transfer, no accept -> EMPTY.
  - neither -> hold.
- FULL (no accept possible):
  - transfer -> ONE; skid moves into main, skid_valid is cleared.
  - no transfer -> hold; out_data/out_rc stay stable.
- Latency: an entry accepted at edge t is presented at edge t+1 when the stage was EMPTY, or when ONE with a simultaneous transfer.
- Ordering is strict FIFO; no entry is dropped or duplicated.
- ovf_sticky:
  - Set at an accept with fn=00 and v=1.
  - Cleared when ovf_clr=1.
  - Simultaneous set and clear in one cycle: set wins.
  - Compare ops never set it.
- Values while invalid: out_data and out_rc are don't-care when out_valid=0, but registers hold their last value (no X-propagation from reset).
- Reset, synchronous and taking priority over all events:
  - State -> EMPTY.
  - out_valid=0, in_ready=1 (on the cycle after reset is sampled).
  - out_data=0, out_rc=0, ovf_sticky=0.
  - Any in-flight entries are discarded.
  - An accept in the reset cycle is ignored.

Test Plan:
- Pass-through: reset, fn=00, arithout=0x0000_0005, rc_in=3, out_ready=1 -> next cycle out_valid=1, out_data=5, out_rc=3; one cycle later out_valid=0.
- Compares:
  - fn=10 with n=1,v=0 -> out_data=1.
  - fn=10 with n=1,v=1 -> 0.
  - fn=01 with z=1 -> 1.
  - fn=11 with z=0,n=0,v=1 -> 1.
  - fn=11 with z=0,n=0,v=0 -> 0.
- Back-pressure: out_ready=0, accept A=0x11 then B=0x22 -> state FULL, in_ready=0, out_data holds 0x11. Raise out_ready -> 0x11 then 0x22 on consecutive cycles, and in_ready returns to 1 after the first transfer.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with data 1..8 -> outputs 1..8 in order on 8 consecutive cycles, in_ready stays 1.
- Sticky overflow:
  - fn=00, v=1 accept -> ovf_sticky=1.
  - fn=01 with v=1 -> no effect.
  - ovf_clr and an fn=00, v=1 accept in the same cycle -> ovf_sticky stays 1.
  - ovf_clr alone -> 0.
- Reset mid-operation: in FULL with out_ready=0, assert reset for one cycle -> out_valid=0, in_ready=1, ovf_sticky=0, out_data=0; the two buffered entries are never presented.
